// File: rtl/snes_pad_device.sv
// SNES controller device side: filters the host's latch/clock lines, latches the
// button state on the latch falling edge and shifts 16 bits out LSB-first.
module snes_pad_device #(
    parameter int FILTER  = 3,
    parameter int TIMEOUT = 21477
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] buttons,
    input  logic        joy_strb,
    input  logic        joy_clk,
    output logic        joy_data,
    output logic        busy,
    output logic        poll_done,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam int CH_STRB = 0;
    localparam int CH_CLK  = 1;

    // Host pins, one channel each: [0] = strobe, [1] = shift clock.
    logic [1:0] w_pin;
    logic [1:0] w_accept;
    logic [1:0] w_filt_new;

    assign w_pin = {joy_clk, joy_strb};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_in
            // Strobe idles low, shift clock idles high.
            localparam logic RST_LVL = (gi == CH_CLK);

            logic       r_s1;
            logic       r_s2;
            logic       r_filt;
            logic [3:0] r_fcnt;
            logic       w_acc;

            // A new level is taken once it has differed from the filtered value for FILTER cycles.
            assign w_acc = (r_s2 != r_filt) && (r_fcnt == 4'(FILTER - 1));

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1   <= RST_LVL;
                    r_s2   <= RST_LVL;
                    r_filt <= RST_LVL;
                    r_fcnt <= 4'd0;
                end else begin
                    r_s1 <= w_pin[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_filt) begin
                        r_fcnt <= 4'd0;
                    end else if (w_acc) begin
                        r_filt <= r_s2;
                        r_fcnt <= 4'd0;
                    end else begin
                        r_fcnt <= r_fcnt + 4'd1;
                    end
                end
            end

            assign w_accept[gi]   = w_acc;
            assign w_filt_new[gi] = w_acc ? r_s2 : r_filt;
        end
    endgenerate

    // The FSM reacts to the level being accepted this cycle, not the registered one,
    // which keeps pin-to-wire latency at 2 + FILTER cycles.
    logic w_strb;
    logic w_clk_rise;

    assign w_strb     = w_filt_new[CH_STRB];
    assign w_clk_rise = w_accept[CH_CLK] & w_filt_new[CH_CLK];

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_sr;
    logic [15:0] w_sr_next;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_next;
    logic [15:0] r_tmo;
    logic [15:0] w_tmo_next;
    logic        r_poll_done;
    logic        w_poll_done_next;
    logic        r_tmo_err;
    logic        w_tmo_err_next;

    logic [15:0] w_load;
    logic [15:0] w_tmo_inc;
    logic        w_tmo_hit;

    // Pad ID nibble is logically 0000 (nothing pressed), i.e. high on the active-low wire.
    assign w_load    = ~{4'b0000, buttons};
    assign w_tmo_inc = r_tmo + 16'd1;
    assign w_tmo_hit = (r_tmo == 16'(TIMEOUT - 1));

    always_comb begin
        w_state_next     = r_state;
        w_sr_next        = r_sr;
        w_cnt_next       = r_cnt;
        w_tmo_next       = r_tmo;
        w_poll_done_next = 1'b0;
        w_tmo_err_next   = 1'b0;

        if (w_strb) begin
            // Strobe wins over everything, including a same-cycle clock edge.
            w_state_next = S_LATCH;
            w_sr_next    = w_load;
            w_cnt_next   = 5'd0;
            w_tmo_next   = 16'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                end
                S_LATCH: begin
                    w_state_next = S_SHIFT;
                    w_cnt_next   = 5'd0;
                    w_tmo_next   = 16'd0;
                end
                S_SHIFT: begin
                    if (w_clk_rise) begin
                        w_sr_next  = {1'b1, r_sr[15:1]};
                        w_cnt_next = r_cnt + 5'd1;
                        w_tmo_next = 16'd0;
                        if (r_cnt == 5'd15) begin
                            w_state_next     = S_DONE;
                            w_poll_done_next = 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        w_state_next   = S_IDLE;
                        w_sr_next      = 16'hFFFF;
                        w_cnt_next     = 5'd0;
                        w_tmo_next     = 16'd0;
                        w_tmo_err_next = 1'b1;
                    end else begin
                        w_tmo_next = w_tmo_inc;
                    end
                end
                S_DONE: begin
                    if (w_clk_rise) begin
                        w_tmo_next = 16'd0;
                    end else if (w_tmo_hit) begin
                        w_state_next = S_IDLE;
                        w_sr_next    = 16'hFFFF;
                        w_cnt_next   = 5'd0;
                        w_tmo_next   = 16'd0;
                    end else begin
                        w_tmo_next = w_tmo_inc;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sr        <= 16'hFFFF;
            r_cnt       <= 5'd0;
            r_tmo       <= 16'd0;
            r_poll_done <= 1'b0;
            r_tmo_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sr        <= w_sr_next;
            r_cnt       <= w_cnt_next;
            r_tmo       <= w_tmo_next;
            r_poll_done <= w_poll_done_next;
            r_tmo_err   <= w_tmo_err_next;
        end
    end

    always_comb begin
        joy_data = 1'b1;
        unique case (r_state)
            S_LATCH, S_SHIFT: joy_data = r_sr[0];
            S_DONE:           joy_data = 1'b0;
            default:          joy_data = 1'b1;
        endcase
    end

    assign busy        = (r_state != S_IDLE);
    assign poll_done   = r_poll_done;
    assign timeout_err = r_tmo_err;

endmodule
